// File: rtl/uart_report_sender.sv
// Builds VT100 replies (DSR status, cursor position, device attributes) and
// feeds them byte-by-byte to the async transmitter using a start/busy handshake.
module uart_report_sender #(
  parameter logic [7:0] DA_CLASS   = 8'h32,
  parameter int         MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqStatus,
  input  logic       reqCursor,
  input  logic       reqIdentify,
  input  logic [7:0] cursorRow,
  input  logic [7:0] cursorCol,
  input  logic       txBusy,
  output logic       txStart,
  output logic [7:0] txData,
  output logic       busy
);

  localparam int BCD_W = 4 * MAX_DIGITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_LOAD, S_STROBE, S_WAIT_BUSY, S_WAIT_IDLE
  } state_t;

  typedef enum logic [1:0] {K_STATUS, K_IDENT, K_CURSOR} kind_t;

  state_t             r_state, w_next;
  kind_t              r_kind;
  logic               r_pendStatus, r_pendCursor, r_pendIdent;
  logic               w_takeStatus, w_takeCursor, w_takeIdent;
  logic [8:0]         r_binRow, r_binCol;
  logic [BCD_W-1:0]   r_bcdRow, r_bcdCol;
  logic [3:0]         r_cnt, r_idx;
  logic [7:0]         r_txData, w_byte;
  logic [3:0]         w_len, w_rowLen, w_colLen;
  logic               w_last;

  function automatic logic [BCD_W-1:0] dabbleStep(input logic [BCD_W-1:0] bcd,
                                                  input logic bitIn);
    logic [BCD_W-1:0] adj;
    for (int d = 0; d < MAX_DIGITS; d++) begin
      adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
    end
    return BCD_W'({adj, bitIn});
  endfunction

  function automatic logic [3:0] digitLen(input logic [BCD_W-1:0] bcd);
    if (bcd[11:8] != 4'd0)     return 4'd3;
    else if (bcd[7:4] != 4'd0) return 4'd2;
    else                       return 4'd1;
  endfunction

  // k counts from the most significant displayed digit
  function automatic logic [7:0] digitChar(input logic [BCD_W-1:0] bcd,
                                           input logic [3:0] len,
                                           input logic [3:0] k);
    logic [3:0] pos;
    pos = len - 4'd1 - k;
    return {4'h3, bcd[4*pos +: 4]};
  endfunction

  always_comb begin
    w_byte   = 8'h00;
    w_len    = 4'd1;
    w_rowLen = digitLen(r_bcdRow);
    w_colLen = digitLen(r_bcdCol);
    case (r_kind)
      K_STATUS: begin
        w_len = 4'd4;
        case (r_idx)
          4'd0:    w_byte = 8'h1B;
          4'd1:    w_byte = 8'h5B;
          4'd2:    w_byte = 8'h30;
          default: w_byte = 8'h6E;
        endcase
      end
      K_IDENT: begin
        w_len = 4'd7;
        case (r_idx)
          4'd0:    w_byte = 8'h1B;
          4'd1:    w_byte = 8'h5B;
          4'd2:    w_byte = 8'h3F;
          4'd3:    w_byte = 8'h31;
          4'd4:    w_byte = 8'h3B;
          4'd5:    w_byte = DA_CLASS;
          default: w_byte = 8'h63;
        endcase
      end
      default: begin
        w_len = 4'd4 + w_rowLen + w_colLen;
        if (r_idx == 4'd0)                             w_byte = 8'h1B;
        else if (r_idx == 4'd1)                        w_byte = 8'h5B;
        else if (r_idx < 4'd2 + w_rowLen)              w_byte = digitChar(r_bcdRow, w_rowLen, r_idx - 4'd2);
        else if (r_idx == 4'd2 + w_rowLen)             w_byte = 8'h3B;
        else if (r_idx < 4'd3 + w_rowLen + w_colLen)   w_byte = digitChar(r_bcdCol, w_colLen, r_idx - 4'd3 - w_rowLen);
        else                                           w_byte = 8'h52;
      end
    endcase
    w_last = (r_idx == w_len - 4'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_takeStatus = 1'b0;
    w_takeCursor = 1'b0;
    w_takeIdent  = 1'b0;
    txStart      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pendCursor) begin
          w_takeCursor = 1'b1;
          w_next       = S_CONVERT;
        end else if (r_pendStatus) begin
          w_takeStatus = 1'b1;
          w_next       = S_LOAD;
        end else if (r_pendIdent) begin
          w_takeIdent  = 1'b1;
          w_next       = S_LOAD;
        end
      end
      S_CONVERT:   if (r_cnt == 4'd8) w_next = S_LOAD;
      S_LOAD:      if (!txBusy) w_next = S_STROBE;
      S_STROBE: begin
        txStart = 1'b1;
        w_next  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (txBusy) w_next = S_WAIT_IDLE;
      S_WAIT_IDLE: if (!txBusy) w_next = w_last ? S_IDLE : S_LOAD;
      default:     w_next = S_IDLE;
    endcase
  end

  // A pulse on an already-pending type merges into it; acceptance clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pendStatus <= 1'b0;
      r_pendCursor <= 1'b0;
      r_pendIdent  <= 1'b0;
      r_kind       <= K_STATUS;
      r_binRow     <= '0;
      r_binCol     <= '0;
      r_bcdRow     <= '0;
      r_bcdCol     <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_txData     <= 8'h00;
    end else begin
      r_pendStatus <= (r_pendStatus | reqStatus)   & ~w_takeStatus;
      r_pendCursor <= (r_pendCursor | reqCursor)   & ~w_takeCursor;
      r_pendIdent  <= (r_pendIdent  | reqIdentify) & ~w_takeIdent;
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          r_cnt <= '0;
          if (w_takeCursor) begin
            r_kind   <= K_CURSOR;
            r_binRow <= {1'b0, cursorRow} + 9'd1;
            r_binCol <= {1'b0, cursorCol} + 9'd1;
            r_bcdRow <= '0;
            r_bcdCol <= '0;
          end else if (w_takeStatus) begin
            r_kind <= K_STATUS;
          end else if (w_takeIdent) begin
            r_kind <= K_IDENT;
          end
        end
        S_CONVERT: begin
          r_bcdRow <= dabbleStep(r_bcdRow, r_binRow[8]);
          r_bcdCol <= dabbleStep(r_bcdCol, r_binCol[8]);
          r_binRow <= {r_binRow[7:0], 1'b0};
          r_binCol <= {r_binCol[7:0], 1'b0};
          r_cnt    <= r_cnt + 4'd1;
        end
        S_LOAD:      if (!txBusy) r_txData <= w_byte;
        S_WAIT_IDLE: if (!txBusy && !w_last) r_idx <= r_idx + 4'd1;
        default: ;
      endcase
    end
  end

  assign txData = r_txData;
  assign busy   = (r_state != S_IDLE) | r_pendStatus | r_pendCursor | r_pendIdent;

endmodule

// File: tb/tb_uart_report_sender.sv
// Directed bench for uart_report_sender with a 10-cycle transmitter busy model.
module tb_uart_report_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       reqStatus, reqCursor, reqIdentify;
  logic [7:0] cursorRow, cursorCol;
  logic       txBusy, txStart, busy;
  logic [7:0] txData;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got[$];
  logic [7:0] expq[$];
  int         busyCnt = 0;
  logic       modelBusy = 1'b0;
  logic       forceBusy = 1'b0;
  int         strobeWhileBusy = 0;

  always #5 clk = ~clk;

  assign txBusy = modelBusy | forceBusy;

  uart_report_sender #(.DA_CLASS(8'h32), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst),
    .reqStatus(reqStatus), .reqCursor(reqCursor), .reqIdentify(reqIdentify),
    .cursorRow(cursorRow), .cursorCol(cursorCol),
    .txBusy(txBusy), .txStart(txStart), .txData(txData), .busy(busy)
  );

  // Transmitter model: captures strobed bytes and stays busy for 10 cycles
  always @(negedge clk) begin
    if (txStart) begin
      got.push_back(txData);
      if (txBusy) strobeWhileBusy++;
      busyCnt = 10;
    end else if (busyCnt > 0) begin
      busyCnt--;
    end
    modelBusy = (busyCnt > 0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic c, input logic i);
    @(negedge clk);
    reqStatus = s; reqCursor = c; reqIdentify = i;
    @(negedge clk);
    reqStatus = 1'b0; reqCursor = 1'b0; reqIdentify = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_txBusyDone"}, 32'(txBusy), 32'd0);
  endtask

  task automatic checkBytes(input string tag);
    checkOutput({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      checkOutput($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(expq[i]));
    got.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen;
    int n;
    rst = 1'b0;
    reqStatus = 1'b0; reqCursor = 1'b0; reqIdentify = 1'b0;
    cursorRow = 8'd0; cursorCol = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_txStart", 32'(txStart), 32'd0);
    checkOutput("rst_txData", 32'(txData), 32'h00);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Status reply and its three-cycle latency
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lat_busy", 32'(busy), 32'd1);
    checkOutput("lat_c1", 32'(txStart), 32'd0);
    @(negedge clk);
    checkOutput("lat_c2", 32'(txStart), 32'd0);
    @(negedge clk);
    checkOutput("lat_c3", 32'(txStart), 32'd1);
    checkOutput("lat_data", 32'(txData), 32'h1B);
    waitIdle("status");
    expq = '{8'h1B, 8'h5B, 8'h30, 8'h6E};
    checkBytes("status");

    // Cursor reply with a mid-reply input change that must be ignored
    cursorRow = 8'd3; cursorCol = 8'd10;
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    cursorCol = 8'd0;
    waitIdle("cur");
    expq = '{8'h1B, 8'h5B, 8'h34, 8'h3B, 8'h31, 8'h31, 8'h52};
    checkBytes("cur");

    cursorRow = 8'd255; cursorCol = 8'd0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitIdle("curMax");
    expq = '{8'h1B, 8'h5B, 8'h32, 8'h35, 8'h36, 8'h3B, 8'h31, 8'h52};
    checkBytes("curMax");

    cursorRow = 8'd0; cursorCol = 8'd99;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitIdle("cur99");
    expq = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h31, 8'h30, 8'h30, 8'h52};
    checkBytes("cur99");

    // All three at once, then a duplicate status request that must merge
    cursorRow = 8'd4; cursorCol = 8'd7;
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIdle("multi");
    expq = '{8'h1B, 8'h5B, 8'h35, 8'h3B, 8'h38, 8'h52,
             8'h1B, 8'h5B, 8'h30, 8'h6E,
             8'h1B, 8'h5B, 8'h3F, 8'h31, 8'h3B, 8'h32, 8'h63};
    checkBytes("multi");

    // Transmitter busy before the first byte
    forceBusy = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    checkOutput("hs_noStrobe", 32'(got.size()), 32'd0);
    checkOutput("hs_busyHeld", 32'(busy), 32'd1);
    forceBusy = 1'b0;
    waitIdle("hs");
    expq = '{8'h1B, 8'h5B, 8'h30, 8'h6E};
    checkBytes("hs");

    // Asynchronous reset during the third byte strobe of a cursor reply
    cursorRow = 8'd3; cursorCol = 8'd10;
    applyStimulus(1'b0, 1'b1, 1'b0);
    seen = 0;
    n = 0;
    while (seen < 3 && n < 2000) begin
      @(posedge clk);
      #2;
      if (txStart) seen++;
      n++;
    end
    checkOutput("rst_reach3rd", 32'(seen), 32'd3);
    checkOutput("rst_preStart", 32'(txStart), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst_asyncStart", 32'(txStart), 32'd0);
    checkOutput("rst_asyncBusy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("rst_noMore", 32'(got.size()), 32'd2);
    checkOutput("rst_idleAfter", 32'(busy), 32'd0);
    got.delete();

    // Normal operation resumes after the reset
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle("ident");
    expq = '{8'h1B, 8'h5B, 8'h3F, 8'h31, 8'h3B, 8'h32, 8'h63};
    checkBytes("ident");

    checkOutput("noStrobeWhileBusy", 32'(strobeWhileBusy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
